fir_out_stage: RTL



---
 rtl/fir_out_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fir_out_stage.sv
// rtl/fir_out_stage.sv - FIR output stage: warm-up discard, decimation, divide-by-gain with round half-up, saturation
// The divider is a restoring divider that produces one quotient bit per cycle.
module fir_out_stage #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int GAIN   = 12,
  parameter int DECIM  = 64,
  parameter int WARMUP = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             sat
);

  localparam int DW = IN_W + 1;
  localparam int RW = $clog2(GAIN + 1) + 1;
  localparam int IW = $clog2(DW + 1);
  localparam int WW = $clog2(WARMUP + 2);
  localparam int PW = 16;

  localparam logic [RW-1:0] GAIN_R  = RW'(GAIN);
  localparam logic [DW-1:0] HALF    = DW'(GAIN / 2);
  localparam logic [IW-1:0] LAST_IT = IW'(DW - 1);
  localparam logic [WW-1:0] WARM_N  = WW'(WARMUP);
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic [PW-1:0] phase;
  logic [IW-1:0] iter;
  logic [DW-1:0] dvd;
  logic [DW-1:0] quot;
  logic [RW-2:0] rem;

  logic          warm_done;
  logic          sample;
  logic          select;
  logic          slot_free;
  logic [RW-1:0] rem_sh;
  logic [RW-1:0] diff;
  logic          q_bit;
  logic [RW-2:0] rem_nx;
  logic [DW-1:0] q_fin;
  logic          fin_over;

  function automatic logic [OUT_W-1:0] clamp(input logic [DW-1:0] q);
    return (|q[DW-1:OUT_W]) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
  endfunction

  always_comb begin
    warm_done = (warm_cnt == WARM_N);
    sample    = in_valid && warm_done;
    select    = sample && (phase == '0);
    slot_free = !out_valid || out_ready;
    rem_sh    = {rem, dvd[DW-1]};
    diff      = rem_sh - GAIN_R;
    // The divisor is below 2^(RW-1), so a borrow always lands in the MSB.
    q_bit     = ~diff[RW-1];
    rem_nx    = q_bit ? diff[RW-2:0] : rem_sh[RW-2:0];
    q_fin     = {quot[DW-2:0], q_bit};
    fin_over  = |q_fin[DW-1:OUT_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      phase     <= '0;
      iter      <= '0;
      dvd       <= '0;
      quot      <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (in_valid && !warm_done)
        warm_cnt <= warm_cnt + 1'b1;

      if (sample)
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;

      if (out_valid && out_ready)
        out_valid <= 1'b0;

      // State is sampled before the edge: selections seen outside IDLE are lost.
      if (select && state != IDLE)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (select) begin
            dvd   <= {1'b0, in_data} + HALF;
            quot  <= '0;
            rem   <= '0;
            iter  <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          dvd  <= dvd << 1;
          rem  <= rem_nx;
          quot <= q_fin;
          iter <= iter + 1'b1;
          if (iter == LAST_IT) begin
            if (fin_over)
              sat <= 1'b1;
            if (slot_free) begin
              out_data  <= clamp(q_fin);
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            out_data  <= clamp(quot);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
